// File: rtl/frame_ring_controller.sv
// Frame buffer ring: writer, processing and display ownership tracking.
// One state per buffer; same-cycle events resolve in a fixed order.
module frame_ring_controller #(
  parameter int          NUM_BUFS     = 5,
  parameter int          ADDR_W       = 32,
  parameter logic [31:0] MAIN_BASE    = 32'h7000_0000,
  parameter logic [31:0] OVL_BASE     = 32'h7800_0000,
  parameter logic [31:0] FRAME_STRIDE = 32'h0100_0000,
  parameter int          DROP_CNT_W   = 16
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  min_delay_i,
  input  logic                  wr_start_i,
  input  logic                  wr_done_i,
  input  logic                  swap_req_i,
  input  logic                  disp_vsync_i,
  output logic                  wr_active_o,
  output logic [ADDR_W-1:0]     wr_addr_o,
  output logic [ADDR_W-1:0]     proc_addr_o,
  output logic [ADDR_W-1:0]     ovl_draw_addr_o,
  output logic [ADDR_W-1:0]     disp_addr_o,
  output logic [ADDR_W-1:0]     ovl_rd_addr_o,
  output logic                  swap_ack_o,
  output logic                  swap_new_o,
  output logic [DROP_CNT_W-1:0] drop_cnt_o,
  output logic                  err_o
);

  localparam int IW = $clog2(NUM_BUFS);

  typedef enum logic [2:0] {
    S_FREE, S_WRITING, S_READY,
    S_PROC, S_QUEUED, S_DISP
  } buf_st_t;

  typedef buf_st_t [NUM_BUFS-1:0] ring_t;

  typedef struct packed {
    logic          hit;
    logic [IW-1:0] idx;
  } find_t;

  function automatic find_t find(
    ring_t r, buf_st_t s
  );
    find_t f;
    f = '0;
    for (int i = NUM_BUFS-1; i >= 0; i--)
      if (r[i] == s) begin
        f.hit = 1'b1;
        f.idx = IW'(i);
      end
    return f;
  endfunction

  function automatic logic [ADDR_W-1:0] addr(
    logic [31:0] base, logic [IW-1:0] idx
  );
    logic [63:0] a;
    a = 64'(base) + 64'(idx) * 64'(FRAME_STRIDE);
    return a[ADDR_W-1:0];
  endfunction

  function automatic ring_t reset_ring();
    ring_t r;
    for (int i = 0; i < NUM_BUFS; i++)
      r[i] = (i == 0) ? S_DISP :
             (i == 1) ? S_PROC : S_FREE;
    return r;
  endfunction

  ring_t st_q, st_d;
  logic  [1:0] inc;
  logic  ev_err, inv_bad;
  logic  act_d, new_d;
  logic  [ADDR_W-1:0] wr_addr_d, proc_addr_d;
  logic  [ADDR_W-1:0] ovl_draw_d, disp_addr_d;
  logic  [ADDR_W-1:0] ovl_rd_d;
  logic  [DROP_CNT_W-1:0] drop_d;
  logic  [DROP_CNT_W:0]   drop_sum;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      st_q            <= reset_ring();
      wr_active_o     <= 1'b0;
      wr_addr_o       <= addr(MAIN_BASE, IW'(0));
      proc_addr_o     <= addr(MAIN_BASE, IW'(1));
      ovl_draw_addr_o <= addr(OVL_BASE, IW'(1));
      disp_addr_o     <= addr(MAIN_BASE, IW'(0));
      ovl_rd_addr_o   <= addr(OVL_BASE, IW'(0));
      swap_ack_o      <= 1'b0;
      swap_new_o      <= 1'b0;
      drop_cnt_o      <= '0;
      err_o           <= 1'b0;
    end else begin
      st_q            <= st_d;
      wr_active_o     <= act_d;
      wr_addr_o       <= wr_addr_d;
      proc_addr_o     <= proc_addr_d;
      ovl_draw_addr_o <= ovl_draw_d;
      disp_addr_o     <= disp_addr_d;
      ovl_rd_addr_o   <= ovl_rd_d;
      swap_ack_o      <= swap_req_i;
      swap_new_o      <= new_d;
      drop_cnt_o      <= drop_d;
      err_o           <= err_o | ev_err | inv_bad;
    end
  end

  // Each step sees the ring left by the previous one.
  always_comb begin
    find_t w, r, q, p, d, f;
    st_d   = st_q;
    inc    = 2'd0;
    ev_err = 1'b0;
    act_d  = wr_active_o;
    new_d  = 1'b0;
    w = '0; r = '0; q = '0;
    p = '0; d = '0; f = '0;

    if (wr_done_i) begin
      w = find(st_d, S_WRITING);
      r = find(st_d, S_READY);
      if (w.hit) begin
        if (r.hit) begin
          st_d[r.idx] = S_FREE;
          inc = inc + 2'd1;
        end
        st_d[w.idx] = S_READY;
        act_d = 1'b0;
      end else begin
        ev_err = 1'b1;
      end
    end

    if (swap_req_i) begin
      r = find(st_d, S_READY);
      q = find(st_d, S_QUEUED);
      p = find(st_d, S_PROC);
      if (r.hit) begin
        if (q.hit) begin
          st_d[q.idx] = S_FREE;
          inc = inc + 2'd1;
        end
        if (p.hit) st_d[p.idx] = S_QUEUED;
        st_d[r.idx] = S_PROC;
        new_d = 1'b1;
      end
    end

    if (disp_vsync_i) begin
      r = find(st_d, S_READY);
      q = find(st_d, S_QUEUED);
      d = find(st_d, S_DISP);
      if (min_delay_i && r.hit) begin
        if (d.hit) st_d[d.idx] = S_FREE;
        st_d[r.idx] = S_DISP;
      end else if (q.hit) begin
        if (d.hit) st_d[d.idx] = S_FREE;
        st_d[q.idx] = S_DISP;
      end
    end

    if (wr_start_i) begin
      w = find(st_d, S_WRITING);
      f = find(st_d, S_FREE);
      r = find(st_d, S_READY);
      if (w.hit) begin
        inc = inc + 2'd1;
        act_d = 1'b1;
      end else if (f.hit) begin
        st_d[f.idx] = S_WRITING;
        act_d = 1'b1;
      end else if (r.hit) begin
        st_d[r.idx] = S_WRITING;
        inc = inc + 2'd1;
        act_d = 1'b1;
      end else begin
        ev_err = 1'b1;
      end
    end
  end

  always_comb begin
    int n_w, n_r, n_p, n_q, n_d;
    n_w = 0; n_r = 0; n_p = 0;
    n_q = 0; n_d = 0;
    for (int i = 0; i < NUM_BUFS; i++) begin
      unique case (st_d[i])
        S_WRITING: n_w++;
        S_READY:   n_r++;
        S_PROC:    n_p++;
        S_QUEUED:  n_q++;
        S_DISP:    n_d++;
        default:   ;
      endcase
    end
    inv_bad = (n_p != 1) || (n_d != 1) ||
              (n_w > 1) || (n_r > 1) || (n_q > 1);
  end

  always_comb begin
    find_t w, p, d;
    w = find(st_d, S_WRITING);
    p = find(st_d, S_PROC);
    d = find(st_d, S_DISP);
    wr_addr_d   = w.hit ? addr(MAIN_BASE, w.idx)
                        : wr_addr_o;
    proc_addr_d = addr(MAIN_BASE, p.idx);
    ovl_draw_d  = addr(OVL_BASE, p.idx);
    disp_addr_d = addr(MAIN_BASE, d.idx);
    ovl_rd_d    = addr(OVL_BASE, d.idx);
    drop_sum    = {1'b0, drop_cnt_o} +
                  (DROP_CNT_W+1)'(inc);
    drop_d      = drop_sum[DROP_CNT_W] ? '1 :
                  drop_sum[DROP_CNT_W-1:0];
  end

endmodule

// File: tb/tb_frame_ring_controller.sv
// Directed vector bench for frame_ring_controller.
// Main table on default parameters; small ring covers recycle/saturate.
module tb_frame_ring_controller;

  logic clk = 1'b0;
  logic rst, md, ws, wd, sw, vs;

  logic        wa, ack, nw, err;
  logic [31:0] wr, pr, od, di, orr;
  logic [15:0] drop;

  logic        wa4, ack4, nw4, err4;
  logic [31:0] wr4, pr4, od4, di4, or4;
  logic [1:0]  drop4;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  frame_ring_controller dut (
    .clk_i(clk), .reset_i(rst),
    .min_delay_i(md), .wr_start_i(ws),
    .wr_done_i(wd), .swap_req_i(sw),
    .disp_vsync_i(vs),
    .wr_active_o(wa), .wr_addr_o(wr),
    .proc_addr_o(pr), .ovl_draw_addr_o(od),
    .disp_addr_o(di), .ovl_rd_addr_o(orr),
    .swap_ack_o(ack), .swap_new_o(nw),
    .drop_cnt_o(drop), .err_o(err)
  );

  frame_ring_controller #(
    .NUM_BUFS(4), .DROP_CNT_W(2)
  ) dut4 (
    .clk_i(clk), .reset_i(rst),
    .min_delay_i(md), .wr_start_i(ws),
    .wr_done_i(wd), .swap_req_i(sw),
    .disp_vsync_i(vs),
    .wr_active_o(wa4), .wr_addr_o(wr4),
    .proc_addr_o(pr4), .ovl_draw_addr_o(od4),
    .disp_addr_o(di4), .ovl_rd_addr_o(or4),
    .swap_ack_o(ack4), .swap_new_o(nw4),
    .drop_cnt_o(drop4), .err_o(err4)
  );

  typedef struct {
    logic [5:0]  in;
    logic        wa;
    logic [31:0] wr, pr, od, di, orr;
    logic        ack, nw;
    logic [15:0] drop;
    logic        err;
  } vec_t;

  vec_t v[25];

  function automatic vec_t mk(
    logic [5:0] in, logic a,
    logic [31:0] w, p, o, d, r,
    logic k, n, logic [15:0] dc, logic e
  );
    vec_t t;
    t.in = in; t.wa = a; t.wr = w;
    t.pr = p; t.od = o; t.di = d;
    t.orr = r; t.ack = k; t.nw = n;
    t.drop = dc; t.err = e;
    return t;
  endfunction

  task automatic chk(
    string nm, int idx,
    logic [31:0] act, logic [31:0] exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got=%h want=%h",
               nm, idx, act, exp);
    end
  endtask

  // in = {rst, md, ws, wd, sw, vs}
  task automatic step(logic [5:0] in);
    @(negedge clk);
    {rst, md, ws, wd, sw, vs} = in;
    @(posedge clk);
    #1;
  endtask

  localparam logic [5:0] RST = 6'b100000;
  localparam logic [5:0] MD  = 6'b010000;
  localparam logic [5:0] WS  = 6'b001000;
  localparam logic [5:0] WD  = 6'b000100;
  localparam logic [5:0] SW  = 6'b000010;
  localparam logic [5:0] VS  = 6'b000001;

  localparam logic [31:0] M0 = 32'h7000_0000;
  localparam logic [31:0] M1 = 32'h7100_0000;
  localparam logic [31:0] M2 = 32'h7200_0000;
  localparam logic [31:0] M3 = 32'h7300_0000;
  localparam logic [31:0] O0 = 32'h7800_0000;
  localparam logic [31:0] O1 = 32'h7900_0000;
  localparam logic [31:0] O2 = 32'h7A00_0000;
  localparam logic [31:0] O3 = 32'h7B00_0000;

  initial begin
    {rst, md, ws, wd, sw, vs} = '0;
    v[0]  = mk(RST,     0,M0,M1,O1,M0,O0,0,0,0,0);
    v[1]  = mk(SW,      0,M0,M1,O1,M0,O0,1,0,0,0);
    v[2]  = mk(WS,      1,M2,M1,O1,M0,O0,0,0,0,0);
    v[3]  = mk(WD,      0,M2,M1,O1,M0,O0,0,0,0,0);
    v[4]  = mk(SW,      0,M2,M2,O2,M0,O0,1,1,0,0);
    v[5]  = mk(VS,      0,M2,M2,O2,M1,O1,0,0,0,0);
    v[6]  = mk(MD|WS,   1,M0,M2,O2,M1,O1,0,0,0,0);
    v[7]  = mk(MD|WD,   0,M0,M2,O2,M1,O1,0,0,0,0);
    v[8]  = mk(MD|VS,   0,M0,M2,O2,M0,O0,0,0,0,0);
    v[9]  = mk(WS,      1,M1,M2,O2,M0,O0,0,0,0,0);
    v[10] = mk(WS,      1,M1,M2,O2,M0,O0,0,0,1,0);
    v[11] = mk(WD|SW,   0,M1,M1,O1,M0,O0,1,1,1,0);
    v[12] = mk(WD,      0,M1,M1,O1,M0,O0,0,0,1,1);
    v[13] = mk(6'h3f,   0,M0,M1,O1,M0,O0,0,0,0,0);
    v[14] = mk(WD,      0,M0,M1,O1,M0,O0,0,0,0,1);
    v[15] = mk(RST,     0,M0,M1,O1,M0,O0,0,0,0,0);
    v[16] = mk(MD|WS,   1,M2,M1,O1,M0,O0,0,0,0,0);
    v[17] = mk(MD|WD,   0,M2,M1,O1,M0,O0,0,0,0,0);
    v[18] = mk(MD|VS,   0,M2,M1,O1,M2,O2,0,0,0,0);
    v[19] = mk(WS,      1,M0,M1,O1,M2,O2,0,0,0,0);
    v[20] = mk(RST|WS,  0,M0,M1,O1,M0,O0,0,0,0,0);
    v[21] = mk(WD,      0,M0,M1,O1,M0,O0,0,0,0,1);
    v[22] = mk(RST,     0,M0,M1,O1,M0,O0,0,0,0,0);
    v[23] = mk(VS,      0,M0,M1,O1,M0,O0,0,0,0,0);
    v[24] = mk(MD|VS,   0,M0,M1,O1,M0,O0,0,0,0,0);

    for (int i = 0; i < 25; i++) begin
      step(v[i].in);
      chk("wr_active", i, 32'(wa), 32'(v[i].wa));
      chk("wr_addr", i, wr, v[i].wr);
      chk("proc_addr", i, pr, v[i].pr);
      chk("ovl_draw", i, od, v[i].od);
      chk("disp_addr", i, di, v[i].di);
      chk("ovl_rd", i, orr, v[i].orr);
      chk("swap_ack", i, 32'(ack), 32'(v[i].ack));
      chk("swap_new", i, 32'(nw), 32'(v[i].nw));
      chk("drop", i, 32'(drop), 32'(v[i].drop));
      chk("err", i, 32'(err), 32'(v[i].err));
    end

    // Four-buffer ring: recycle READY, then saturate.
    step(RST);
    step(WS); step(WD); step(SW);
    chk("r4_proc", 0, pr4, M2);
    step(WS); step(WD);
    step(WS);
    chk("r4_wr_addr", 0, wr4, M3);
    chk("r4_active", 0, 32'(wa4), 32'd1);
    chk("r4_drop", 0, 32'(drop4), 32'd1);
    chk("r4_err", 0, 32'(err4), 32'd0);
    step(WS);
    chk("r4_drop", 1, 32'(drop4), 32'd2);
    step(WS);
    chk("r4_drop", 2, 32'(drop4), 32'd3);
    step(WS);
    chk("r4_drop_sat", 3, 32'(drop4), 32'd3);
    step(WD);
    chk("r4_active", 1, 32'(wa4), 32'd0);
    chk("r4_err", 1, 32'(err4), 32'd0);

    // Stale READY discard, then all events at once.
    step(RST);
    step(WS); step(WD); step(WS); step(WD);
    chk("stale_drop", 0, 32'(drop), 32'd1);
    chk("stale_err", 0, 32'(err), 32'd0);
    step(SW);
    chk("stale_proc", 0, pr, M3);
    chk("stale_ovl", 0, od, O3);
    chk("stale_new", 0, 32'(nw), 32'd1);
    step(VS);
    chk("stale_disp", 0, di, M1);
    step(WS);
    step(WS | WD | SW | VS);
    chk("all_active", 0, 32'(wa), 32'd1);
    chk("all_wr", 0, wr, M1);
    chk("all_proc", 0, pr, M0);
    chk("all_disp", 0, di, M3);
    chk("all_new", 0, 32'(nw), 32'd1);
    chk("all_drop", 0, 32'(drop), 32'd1);
    chk("all_err", 0, 32'(err), 32'd0);
    step(6'b0);
    chk("ack_clear", 0, 32'(ack), 32'd0);
    chk("new_clear", 0, 32'(nw), 32'd0);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule

// File: doc/frame_ring_controller.md
FRAME_RING_CONTROLLER -- requirements
Module: frame_ring_controller

Interface
REQ-001 SHALL have parameter NUM_BUFS, default 5, number of frame buffers in the ring; legal range 4..8.
REQ-002 SHALL have parameter ADDR_W, default 32, width of every address output.
REQ-003 SHALL have parameter MAIN_BASE, default 32'h7000_0000, base address of main frame buffer 0.
REQ-004 SHALL have parameter OVL_BASE, default 32'h7800_0000, base address of overlay buffer 0.
REQ-005 SHALL have parameter FRAME_STRIDE, default 32'h0100_0000, address distance between consecutive buffers.
REQ-006 SHALL have parameter DROP_CNT_W, default 16, width of the drop counter.
REQ-007 SHALL have ports: clk_i in 1, the single clock; reset_i in 1, synchronous active-high reset.
REQ-008 SHALL have ports: min_delay_i in 1 (display bypasses processing); wr_start_i in 1 (writer frame-start pulse); wr_done_i in 1 (writer frame-complete pulse); swap_req_i in 1 (software swap pulse); disp_vsync_i in 1 (display frame-boundary pulse).
REQ-009 SHALL have ports: wr_active_o out 1; wr_addr_o, proc_addr_o, ovl_draw_addr_o, disp_addr_o, ovl_rd_addr_o out ADDR_W; swap_ack_o out 1; swap_new_o out 1; drop_cnt_o out DROP_CNT_W; err_o out 1.

Function
REQ-010 SHALL hold one registered state per buffer: FREE, WRITING, READY, PROC, QUEUED, DISP.
REQ-011 SHALL maintain invariants: exactly one PROC, exactly one DISP, at most one each of WRITING, READY, QUEUED.
REQ-012 SHALL drive addr = base + idx*FRAME_STRIDE, truncated to ADDR_W: wr_addr_o/MAIN_BASE/WRITING idx; proc_addr_o/MAIN_BASE and ovl_draw_addr_o/OVL_BASE, both PROC idx; disp_addr_o/MAIN_BASE and ovl_rd_addr_o/OVL_BASE, both DISP idx.
REQ-013 SHALL register all outputs; every event takes effect on outputs exactly one cycle after its input pulse.
REQ-014 SHALL evaluate same-cycle events in fixed order wr_done, swap, vsync, wr_start, each on the state left by the previous step, committing the result in one cycle.
REQ-015 wr_done with a WRITING buffer: WRITING->READY; any prior READY->FREE (stale frame discarded, drop_cnt_o +1); wr_active_o->0.
REQ-016 wr_done with no WRITING buffer: ignored, err_o set.
REQ-017 swap with a READY buffer: PROC->QUEUED (any prior QUEUED->FREE, drop +1), READY->PROC, swap_new_o=1.
REQ-018 swap with no READY: state unchanged, swap_new_o=0.
REQ-019 every swap_req_i SHALL produce a one-cycle swap_ack_o pulse one cycle later, swap_new_o valid in that cycle; swap_new_o=0 whenever swap_ack_o=0.
REQ-020 vsync, min_delay_i=0: if QUEUED exists, DISP->FREE and QUEUED->DISP; else no change.
REQ-021 vsync, min_delay_i=1: if READY exists, DISP->FREE and READY->DISP; else QUEUED as REQ-020; else no change.
REQ-022 wr_start with WRITING active: same buffer restarts, drop +1.
REQ-023 wr_start, idle: lowest-index FREE->WRITING; if no FREE, READY->WRITING (recycled, drop +1); wr_active_o->1.
REQ-024 wr_start with neither FREE nor READY: no change, err_o set.
REQ-025 min_delay_i SHALL be sampled every cycle, no latching; a change affects only later events.
REQ-026 drop_cnt_o SHALL saturate at all-ones; err_o SHALL be sticky until reset.
REQ-027 err_o SHALL also set if any invariant of REQ-011 fails after a commit.

Reset
REQ-028 reset_i SHALL be sampled only on rising clk_i and override all same-cycle events.
REQ-029 reset state: buf0 DISP, buf1 PROC, others FREE; wr_active_o=0, swap_ack_o=0, swap_new_o=0, drop_cnt_o=0, err_o=0.
REQ-030 reset values: disp_addr_o=MAIN_BASE, proc_addr_o=MAIN_BASE+STRIDE, ovl_rd_addr_o=OVL_BASE, ovl_draw_addr_o=OVL_BASE+STRIDE; wr_addr_o=MAIN_BASE.
REQ-031 reset mid-frame SHALL abandon the WRITING buffer without counting a drop.

Verification
REQ-032 Reset, defaults -> disp 0x7000_0000, proc 0x7100_0000, ovl_draw 0x7900_0000, drop 0, err 0.
REQ-033 wr_start, wr_done, swap_req, vsync, min_delay=0 -> wr_addr 0x7200_0000 active; swap_ack=1 swap_new=1 proc 0x7200_0000; disp 0x7100_0000; buf0 FREE.
REQ-034 swap_req after reset, no READY -> swap_ack=1, swap_new=0, proc_addr stays 0x7100_0000.
REQ-035 NUM_BUFS=4, fill READY+QUEUED, second wr_done/wr_start with no FREE -> READY recycled, drop_cnt_o=1, err_o=0.
REQ-036 min_delay=1: wr_start, wr_done, vsync -> disp_addr 0x7200_0000, ovl_rd 0x7A00_0000, buf0 FREE.
REQ-037 wr_done and swap_req same cycle -> swap takes just-completed buffer, swap_new=1; wr_done alone at reset -> err_o=1.
